// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the multicycle multiplier/divider and owns the HI/LO registers
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 33,
  parameter int DIV_CYCLES  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_data,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mult_control,
  output logic        div_control,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, RUN_MULT, RUN_DIV, WRITE} state_t;
  state_t state, state_n;
  logic [5:0] cnt, cnt_n;
  logic unit_div, unit_div_n;
  logic [31:0] op_a_n, op_b_n, hi_n, lo_n;
  logic done_n, div_zero_n;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 6'd1;
    unit_div_n = unit_div;
    op_a_n = op_a;
    op_b_n = op_b;
    hi_n = hi_out;
    lo_n = lo_out;
    done_n = 1'b0;
    div_zero_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (hi_we) hi_n = wr_data;
        if (lo_we) lo_n = wr_data;
        if (start && !op[1]) begin
          if (op[0] && B_in == '0) begin
            done_n = 1'b1;
            div_zero_n = 1'b1;
          end else begin
            state_n = op[0] ? RUN_DIV : RUN_MULT;
            unit_div_n = op[0];
            op_a_n = A_in;
            op_b_n = B_in;
            cnt_n = '0;
          end
        end
      end
      RUN_MULT: state_n = (cnt == 6'(MULT_CYCLES - 1)) ? WRITE : RUN_MULT;
      RUN_DIV:  state_n = (cnt == 6'(DIV_CYCLES - 1)) ? WRITE : RUN_DIV;
      WRITE: begin
        state_n = IDLE;
        hi_n = unit_div ? div_hi : mult_hi;
        lo_n = unit_div ? div_lo : mult_lo;
        done_n = 1'b1;
      end
    endcase
  end
  // Controls are registered from the next state so they track the RUN states exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      unit_div <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      hi_out <= '0;
      lo_out <= '0;
      done <= 1'b0;
      div_zero <= 1'b0;
      mult_control <= 1'b0;
      div_control <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      unit_div <= unit_div_n;
      op_a <= op_a_n;
      op_b <= op_b_n;
      hi_out <= hi_n;
      lo_out <= lo_n;
      done <= done_n;
      div_zero <= div_zero_n;
      mult_control <= state_n == RUN_MULT;
      div_control <= state_n == RUN_DIV;
    end
  end
endmodule
